// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: one DIGIT-wide adder slice reused over WIDTH/DIGIT steps.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via inverted B and carry-in of 1).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid must stay high with stable data until that edge.
  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [DIGIT:0]   step;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_cap;
  logic             carry_cap;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap     = sub ? ~b : b;
  assign carry_cap = sub | cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  assign step     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign res_next = WIDTH'({step[DIGIT-1:0], res_sh} >> DIGIT);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_cap;
            carry <= carry_cap;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= step[DIGIT];
          if (count == LAST) begin
            sum       <= res_next;
            cout      <= step[DIGIT];
            // Carry into the MSB is a^b^s at that bit, so ovf needs no extra slice tap.
            ovf       <= a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ step[DIGIT-1] ^ step[DIGIT];
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            count <= count + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
